instr_inject_seq: RTL
=====================

// Module: instr_inject_seq
// PURPOSE
//  Parametrised instruction injector for CPU bring-up in external-instruction mode.
//  Loads a program into a local buffer, then streams it to the CPU's instr_in and drives mode=1.
//  Stalls, replays (loop mode), drains with NOPs, stops on hlt and enforces a cycle watchdog.
//  Sits between a host/bench loader and cpu(.instr_in, .mode, .hlt).
// PARAMETERS
//  WIDTH         16       instruction width, bits
//  DEPTH         16       buffer entries (power of 2, >=2)
//  NOP_INSTR     16'h0000 word driven when not issuing a program word (ADD R0,R0,R0)
//  DRAIN_CYCLES  5        NOP cycles after the last word (non-loop) before DONE
//  MAX_CYCLES    100000   watchdog limit on RUN+DRAIN cycles
//  localparams:  AW=$clog2(DEPTH), LW=$clog2(DEPTH+1), CW=$clog2(MAX_CYCLES+1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  wr_en        in   1      append wr_data to buffer (honoured only in IDLE/DONE/TIMEOUT)
//  wr_data      in   WIDTH  program word
//  clear        in   1      empty buffer (len:=0); honoured only when not busy
//  full         out  1      len==DEPTH
//  start        in   1      begin streaming from entry 0
//  loop_en      in   1      sampled at start: 1=replay buffer until hlt/timeout
//  stall        in   1      hold current instr_out, do not advance
//  hlt          in   1      CPU halted
//  instr_out    out  WIDTH  to cpu.instr_in (registered)
//  instr_valid  out  1      instr_out is a program word (not NOP)
//  mode         out  1      to cpu.mode; 1 while busy
//  busy         out  1      state is RUN or DRAIN
//  done         out  1      level, state==DONE
//  timeout      out  1      level, state==TIMEOUT
//  issued       out  CW     program words accepted by CPU (stall==0) this run
//  cycles       out  CW     cycles spent in RUN+DRAIN this run
// BEHAVIOUR
//  Reset: state=IDLE, len=0, rd=0, instr_out=NOP_INSTR, instr_valid=0, mode=busy=done=timeout=0,
//   issued=cycles=0, drain_cnt=0, loop latched 0. Buffer contents undefined. Reset mid-run aborts.
//  FSM IDLE -> RUN on start&&len>0 (start with len==0 ignored; stays IDLE, no flags).
//   DONE/TIMEOUT -> RUN on start&&len>0; issued, cycles, rd cleared; flags drop same edge.
//  Start edge: instr_out<=mem[0], instr_valid<=1, mode<=1, rd<=0. First RUN cycle shows mem[0].
//  RUN, stall=0: issued++, rd advances, instr_out<=mem[rd+1]. stall=1: all held, cycles still counts.
//  RUN, word len-1 accepted: loop=1 -> rd wraps to 0, next word is mem[0] (no bubble);
//   loop=0 -> DRAIN, instr_out<=NOP_INSTR, instr_valid<=0, drain_cnt<=0.
//  DRAIN: NOP_INSTR each cycle regardless of stall; after DRAIN_CYCLES cycles -> DONE.
//  hlt=1 in RUN/DRAIN -> DONE next edge, instr_out<=NOP_INSTR, mode<=0.
//  cycles reaches MAX_CYCLES in RUN/DRAIN -> TIMEOUT; same edge as hlt: hlt wins (DONE).
//  DONE/TIMEOUT hold until start or rst; mode=0, instr_out=NOP_INSTR; issued/cycles frozen for readout.
//  Buffer: mem[len]<=wr_data, len++ on wr_en&&!full&&!busy; wr_en while full or busy dropped.
//   clear&&wr_en same cycle: clear wins. Contents persist across runs (replay with start only).
//  Counters saturate at MAX_CYCLES; no wrap.
// STRUCTURE
//  Package instr_inject_pkg: state_e {IDLE,RUN,DRAIN,DONE,TIMEOUT} (3-bit), default NOP constant.
//  Sub-module instr_buf #(WIDTH,DEPTH): reg array, write port, combinational read port, len/full.
//  Top: FSM, rd pointer, drain/cycle/issued counters, registered output stage.
// TESTING
//  1 load B151,A151; start, loop_en=0, no stall -> instr_out B151,A151, 5xNOP, done=1, issued=2.
//  2 same program, stall=1 during cycle 1 of RUN -> B151 held 2 cycles, then A151; issued=2.
//  3 load 4 words, loop_en=1, hlt at cycle 9 -> words repeat w0..w3,w0.. w/o gap; done next edge, mode=0.
//  4 MAX_CYCLES=20, loop_en=1, hlt=0 -> timeout=1 after 20 cycles, cycles=20; hlt+limit same edge -> done.
//  5 write 17 words, DEPTH=16 -> full=1 after 16th, 17th dropped; wr_en during RUN dropped; clear->len=0.
//  6 rst=1 mid-RUN (async, off-edge) -> instr_out=NOP, mode=0, len=0 immediately; start w/ len=0 ignored.

Source files
------------

// File: rtl/instr_inject_pkg.sv
// Shared types and constants for the instruction injector.
//   state_e     : controller states (3-bit)
//   NOP_DEFAULT : default filler word (ADD R0,R0,R0)
//   is_busy()   : true while the injector owns the CPU instruction stream
package instr_inject_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

  function automatic logic is_busy(input state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/instr_buf.sv
// Program buffer: append-only write port, combinational read port, length/full tracking.
//   clk, rst      : clock, async active-high reset (clears length; contents undefined)
//   i_wr_en       : append i_wr_data at entry len (dropped when full)
//   i_wr_data     : program word
//   i_clear       : empty the buffer; wins over i_wr_en
//   i_raddr       : read address
//   o_rdata_c     : combinational read data at i_raddr
//   o_len         : number of valid entries (registered)
//   o_full        : len == DEPTH (registered)
module instr_buf #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clear,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic [LW-1:0]    o_len,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_len;
  logic             r_full;
  logic             w_push;

  assign w_push = i_wr_en && !r_full && !i_clear;

  // Length and full flag; full is precomputed so it is a clean register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_len  <= '0;
      r_full <= 1'b0;
    end else if (w_push) begin
      r_len  <= r_len + LW'(1);
      r_full <= (r_len + LW'(1)) == LW'(DEPTH);
    end
  end

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_len[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];
  assign o_len     = r_len;
  assign o_full    = r_full;

endmodule

// File: rtl/instr_inject_seq.sv
// Instruction injector for CPU bring-up in external-instruction mode.
// Loads a program into a local buffer, then streams it to cpu.instr_in with mode=1,
// honouring stall, optional replay, a NOP drain tail, hlt and a cycle watchdog.
//   clk, rst            : clock, async active-high reset (aborts any run)
//   wr_en, wr_data      : append a program word (only when not busy)
//   clear               : empty the buffer (only when not busy)
//   full                : buffer holds DEPTH words
//   start, loop_en      : begin streaming from entry 0; loop_en latched at start
//   stall, hlt          : CPU hold / CPU halted
//   instr_out           : word to cpu.instr_in
//   instr_valid         : instr_out is a program word
//   mode, busy          : high in RUN/DRAIN
//   done, timeout       : terminal state levels
//   issued, cycles      : per-run accepted words / RUN+DRAIN cycles (saturating)
module instr_inject_seq
  import instr_inject_pkg::*;
#(
  parameter  int unsigned      WIDTH        = 16,
  parameter  int unsigned      DEPTH        = 16,
  parameter  logic [WIDTH-1:0] NOP_INSTR    = WIDTH'(NOP_DEFAULT),
  parameter  int unsigned      DRAIN_CYCLES = 5,
  parameter  int unsigned      MAX_CYCLES   = 100000,
  localparam int unsigned      CW           = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  output logic             full,
  input  logic             start,
  input  logic             loop_en,
  input  logic             stall,
  input  logic             hlt,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CW-1:0]    issued,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  state_e           r_state, w_state_nxt;
  logic [AW-1:0]    r_rd, w_rd_nxt, w_raddr;
  logic [WIDTH-1:0] r_instr_out, w_out_nxt, w_rdata;
  logic             r_instr_valid, w_valid_nxt;
  logic             r_busy, r_done, r_timeout;
  logic [CW-1:0]    r_issued, w_issued_nxt, r_cycles, w_cycles_nxt;
  logic [CW-1:0]    w_cyc_inc, w_iss_inc;
  logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
  logic             r_loop, w_loop_nxt;
  logic [LW-1:0]    w_len;
  logic             w_last, w_limit, w_idle;

  assign w_idle = !is_busy(r_state);

  instr_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (wr_en && w_idle),
    .i_wr_data (wr_data),
    .i_clear   (clear && w_idle),
    .i_raddr   (w_raddr),
    .o_rdata_c (w_rdata),
    .o_len     (w_len),
    .o_full    (full)
  );

  assign w_last    = (LW'(r_rd) + LW'(1)) == w_len;
  assign w_cyc_inc = (r_cycles == CW'(MAX_CYCLES)) ? r_cycles : r_cycles + CW'(1);
  assign w_iss_inc = (r_issued == CW'(MAX_CYCLES)) ? r_issued : r_issued + CW'(1);
  assign w_limit   = (w_cyc_inc == CW'(MAX_CYCLES));

  // Next word to fetch: entry 0 on a start or a loop wrap, otherwise the successor.
  assign w_raddr = (r_state == RUN && !w_last) ? r_rd + AW'(1) : AW'(0);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_nxt     = r_rd;
    w_out_nxt    = r_instr_out;
    w_valid_nxt  = r_instr_valid;
    w_issued_nxt = r_issued;
    w_cycles_nxt = r_cycles;
    w_drain_nxt  = r_drain_cnt;
    w_loop_nxt   = r_loop;
    case (r_state)
      IDLE, DONE, TIMEOUT: begin
        if (start && (w_len != '0)) begin
          w_state_nxt  = RUN;
          w_rd_nxt     = '0;
          w_out_nxt    = w_rdata;
          w_valid_nxt  = 1'b1;
          w_issued_nxt = '0;
          w_cycles_nxt = '0;
          w_loop_nxt   = loop_en;
        end
      end
      RUN: begin
        w_cycles_nxt = w_cyc_inc;
        if (hlt) begin
          w_state_nxt = DONE;
          w_out_nxt   = NOP_INSTR;
          w_valid_nxt = 1'b0;
        end else begin
          if (!stall) w_issued_nxt = w_iss_inc;
          if (w_limit) begin
            w_state_nxt = TIMEOUT;
            w_out_nxt   = NOP_INSTR;
            w_valid_nxt = 1'b0;
          end else if (!stall) begin
            if (w_last && !r_loop) begin
              w_state_nxt = DRAIN;
              w_out_nxt   = NOP_INSTR;
              w_valid_nxt = 1'b0;
              w_drain_nxt = '0;
            end else begin
              w_rd_nxt  = w_raddr;
              w_out_nxt = w_rdata;
            end
          end
        end
      end
      DRAIN: begin
        w_cycles_nxt = w_cyc_inc;
        w_drain_nxt  = r_drain_cnt + DW'(1);
        w_out_nxt    = NOP_INSTR;
        w_valid_nxt  = 1'b0;
        if (hlt) begin
          w_state_nxt = DONE;
        end else if (w_limit) begin
          w_state_nxt = TIMEOUT;
        end else if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_out_nxt   = NOP_INSTR;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rd          <= '0;
      r_instr_out   <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_issued      <= '0;
      r_cycles      <= '0;
      r_drain_cnt   <= '0;
      r_loop        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd          <= w_rd_nxt;
      r_instr_out   <= w_out_nxt;
      r_instr_valid <= w_valid_nxt;
      r_busy        <= is_busy(w_state_nxt);
      r_done        <= (w_state_nxt == DONE);
      r_timeout     <= (w_state_nxt == TIMEOUT);
      r_issued      <= w_issued_nxt;
      r_cycles      <= w_cycles_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_loop        <= w_loop_nxt;
    end
  end

  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;
  assign mode        = r_busy;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign issued      = r_issued;
  assign cycles      = r_cycles;

endmodule
